// File: rtl/ql_mem_pkg.sv
// Shared types for the QL SDRAM arbiter: arbiter states, the access payload
// and the default screen page.
package ql_mem_pkg;

    localparam int unsigned ADDR_W        = 24;
    localparam int unsigned DATA_W        = 16;
    localparam int unsigned VRAM_PAGE_DEF = 2;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CPU_ACC  = 2'd1,
        HOST_ACC = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [1:0]        ds;
        logic [DATA_W-1:0] data;
    } mem_req_t;

endpackage

// File: rtl/ql_host_fifo.sv
// Host write FIFO with registered full/empty/count and a look-ahead port
// exposing the entry behind the head.
module ql_host_fifo #(
    parameter int unsigned WIDTH = 40,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       wdata_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       head_o,
    output logic [WIDTH-1:0]       next_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             full_q;
    logic             empty_q;
    logic             do_push_c;
    logic             do_pop_c;

    always_comb begin
        do_push_c = push_i && !full_q;
        do_pop_c  = pop_i && !empty_q;
        count_d   = count_q;
        if (do_push_c && !do_pop_c) begin
            count_d = count_q + CW'(1);
        end else if (!do_push_c && do_pop_c) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (do_push_c) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (do_pop_c)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_d;
            full_q  <= (count_d == CW'(DEPTH));
            empty_q <= (count_d == '0);
        end
    end

    // Storage needs no reset: pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push_c) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign next_o  = mem_q[rd_ptr_q + PW'(1)];
    assign full_o  = full_q;
    assign empty_o = empty_q;
    assign count_o = count_q;

endmodule

// File: rtl/ql_mem_arbiter.sv
// Slotted SDRAM arbiter between the 68008 bus and the host download stream,
// with VRAM shadow strobe. Define ARB_STATS_EN to add grant/stall counters.
module ql_mem_arbiter
    import ql_mem_pkg::*;
#(
    parameter int unsigned AW           = ADDR_W,
    parameter int unsigned DW           = DATA_W,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned STARVE_LIMIT = 8,
    parameter int unsigned VRAM_PAGE    = VRAM_PAGE_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          sync,
    input  logic          cpu_req,
    input  logic          cpu_wr,
    input  logic [AW-1:0] cpu_addr,
    input  logic [1:0]    cpu_ds,
    input  logic [DW-1:0] cpu_din,
    output logic          cpu_ack,
    output logic [DW-1:0] cpu_dout,
    input  logic          host_valid,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_data,
    output logic          host_ready,
    output logic          host_busy,
    output logic [AW-1:0] sd_addr,
    output logic [DW-1:0] sd_din,
    output logic          sd_we,
    output logic          sd_oe,
    output logic [1:0]    sd_ds,
    input  logic [DW-1:0] sd_dout,
    output logic          vram_we,
    output logic [14:0]   vram_addr,
    output logic [1:0]    vram_ds,
    output logic [DW-1:0] vram_din
`ifdef ARB_STATS_EN
    ,
    output logic [31:0]   stat_cpu,
    output logic [31:0]   stat_host,
    output logic [15:0]   stat_stall
`endif
);

    localparam int unsigned CW  = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned SW  = $clog2(STARVE_LIMIT + 1);
    localparam int unsigned PGW = AW - 15;
    localparam int unsigned FW  = AW + DW;

    arb_state_e      state_q;
    mem_req_t        cur_q;
    logic            sd_we_q, sd_oe_q;
    logic            ack_q;
    logic [DW-1:0]   dout_q;
    logic [SW-1:0]   starve_q, starve_d;
    logic            vram_we_q;
    logic [14:0]     vram_addr_q;
    logic [1:0]      vram_ds_q;
    logic [DW-1:0]   vram_din_q;

    logic [FW-1:0]   fifo_head, fifo_next;
    logic            fifo_full, fifo_empty;
    logic [CW-1:0]   fifo_cnt;

    logic            pop_c, push_c;
    logic [CW-1:0]   cnt_eff_c;
    logic            fifo_has_c, fifo_full_eff_c;
    logic [FW-1:0]   host_sel_c;
    logic            force_host_c, grant_cpu_c, grant_host_c, shadow_c;
    mem_req_t        cpu_req_c, host_req_c;

    assign push_c = host_valid && !fifo_full;

    ql_host_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (reset),
        .push_i  (push_c),
        .wdata_i ({host_addr, host_data}),
        .pop_i   (pop_c),
        .head_o  (fifo_head),
        .next_o  (fifo_next),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_cnt)
    );

    // The in-flight host word stays queued until its slot ends, so arbitration
    // on a completing sync sees the FIFO as it will be after that pop.
    always_comb begin
        pop_c           = sync && (state_q == HOST_ACC);
        cnt_eff_c       = fifo_cnt - (pop_c ? CW'(1) : CW'(0));
        fifo_has_c      = (cnt_eff_c != '0);
        fifo_full_eff_c = (cnt_eff_c == CW'(FIFO_DEPTH));
        host_sel_c      = pop_c ? fifo_next : fifo_head;

        force_host_c = fifo_has_c && ((starve_q >= SW'(STARVE_LIMIT)) || fifo_full_eff_c);
        grant_host_c = sync && (force_host_c || (!cpu_req && fifo_has_c));
        grant_cpu_c  = sync && !force_host_c && cpu_req;

        shadow_c = cur_q.wr && (state_q != IDLE) &&
                   (cur_q.addr[AW-1:15] == PGW'(VRAM_PAGE));

        cpu_req_c.wr   = cpu_wr;
        cpu_req_c.addr = cpu_addr;
        cpu_req_c.ds   = cpu_ds;
        cpu_req_c.data = cpu_din;

        host_req_c.wr   = 1'b1;
        host_req_c.addr = host_sel_c[FW-1:DW];
        host_req_c.ds   = 2'b11;
        host_req_c.data = host_sel_c[DW-1:0];

        starve_d = starve_q;
        if (grant_host_c || !fifo_has_c) begin
            starve_d = '0;
        end else if (grant_cpu_c && (starve_q < SW'(STARVE_LIMIT))) begin
            starve_d = starve_q + SW'(1);
        end
    end

    // Slot FSM: completion of the current access and the next grant share one sync clk.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cur_q       <= '0;
            sd_we_q     <= 1'b0;
            sd_oe_q     <= 1'b0;
            ack_q       <= 1'b0;
            dout_q      <= '0;
            starve_q    <= '0;
            vram_we_q   <= 1'b0;
            vram_addr_q <= '0;
            vram_ds_q   <= '0;
            vram_din_q  <= '0;
        end else begin
            ack_q     <= 1'b0;
            vram_we_q <= 1'b0;
            if (sync) begin
                if (state_q == CPU_ACC) begin
                    ack_q <= 1'b1;
                    if (!cur_q.wr) dout_q <= sd_dout;
                end
                if (shadow_c) begin
                    vram_we_q   <= 1'b1;
                    vram_addr_q <= cur_q.addr[14:0];
                    vram_ds_q   <= cur_q.ds;
                    vram_din_q  <= cur_q.data;
                end
                if (grant_cpu_c) begin
                    state_q <= CPU_ACC;
                    cur_q   <= cpu_req_c;
                    sd_we_q <= cpu_wr;
                    sd_oe_q <= !cpu_wr;
                end else if (grant_host_c) begin
                    state_q <= HOST_ACC;
                    cur_q   <= host_req_c;
                    sd_we_q <= 1'b1;
                    sd_oe_q <= 1'b0;
                end else begin
                    state_q <= IDLE;
                    sd_we_q <= 1'b0;
                    sd_oe_q <= 1'b0;
                end
                starve_q <= starve_d;
            end
        end
    end

    assign cpu_ack    = ack_q;
    assign cpu_dout   = dout_q;
    assign host_ready = !fifo_full;
    assign host_busy  = !fifo_empty;
    assign sd_addr    = cur_q.addr;
    assign sd_din     = cur_q.data;
    assign sd_ds      = cur_q.ds;
    assign sd_we      = sd_we_q;
    assign sd_oe      = sd_oe_q;
    assign vram_we    = vram_we_q;
    assign vram_addr  = vram_addr_q;
    assign vram_ds    = vram_ds_q;
    assign vram_din   = vram_din_q;

`ifdef ARB_STATS_EN
    logic [31:0] stat_cpu_q, stat_host_q;
    logic [15:0] stat_stall_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_cpu_q   <= '0;
            stat_host_q  <= '0;
            stat_stall_q <= '0;
        end else begin
            if (grant_cpu_c && (stat_cpu_q != '1))   stat_cpu_q  <= stat_cpu_q + 32'd1;
            if (grant_host_c && (stat_host_q != '1)) stat_host_q <= stat_host_q + 32'd1;
            if (grant_host_c && cpu_req && (stat_stall_q != '1))
                stat_stall_q <= stat_stall_q + 16'd1;
        end
    end

    assign stat_cpu   = stat_cpu_q;
    assign stat_host  = stat_host_q;
    assign stat_stall = stat_stall_q;
`endif

endmodule
